// File: rtl/cpu_job_dispatcher.sv
// Streams multiply jobs into simple_cpu_top: accept, start, wait with timeout, respond, reset CPU.
// Optional self-check of CPU results is enabled by defining CPU_DISPATCH_SELFCHECK_EN.
module cpu_job_dispatcher #(
  parameter int BIT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int CPU_RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 cpu_start,
  output logic [BIT_WIDTH-1:0] cpu_operand_a,
  output logic [BIT_WIDTH-1:0] cpu_operand_b,
  output logic                 cpu_rst_n,
  input  logic [BIT_WIDTH-1:0] cpu_result,
  input  logic                 cpu_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_result,
  output logic                 out_timeout,
  output logic [15:0]          out_cycles,
  output logic                 out_mismatch,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_CPU_RST,
    S_SETTLE,
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TO_FULL  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] RST_LAST = 16'(CPU_RST_CYCLES - 1);

  state_e               state_q;
  logic [15:0]          cnt_q;
  logic [BIT_WIDTH-1:0] opa_q;
  logic [BIT_WIDTH-1:0] opb_q;
  logic [BIT_WIDTH-1:0] res_q;
  logic                 to_q;
  logic [15:0]          cyc_q;

  logic accept;
  logic wait_done;
  logic wait_to;

  assign accept    = (state_q == S_IDLE) & in_valid;
  assign wait_done = (state_q == S_WAIT) & cpu_done;
  assign wait_to   = (state_q == S_WAIT) & ~cpu_done & (cnt_q == TO_LAST);

  assign in_ready      = (state_q == S_IDLE);
  assign cpu_start     = (state_q == S_START);
  assign cpu_rst_n     = (state_q != S_CPU_RST);
  assign out_valid     = (state_q == S_OUT);
  assign busy          = (state_q != S_IDLE);
  assign cpu_operand_a = opa_q;
  assign cpu_operand_b = opb_q;
  assign out_result    = res_q;
  assign out_timeout   = to_q;
  assign out_cycles    = cyc_q;

  // Job sequencing FSM with its shared counter and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CPU_RST;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      unique case (state_q)
        S_CPU_RST: begin
          if (cnt_q == RST_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_SETTLE: state_q <= S_IDLE;
        S_IDLE: begin
          if (accept) begin
            opa_q   <= in_a;
            opb_q   <= in_b;
            state_q <= S_START;
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cpu_done) begin
            res_q   <= cpu_result;
            cyc_q   <= cnt_q;
            to_q    <= 1'b0;
            state_q <= S_OUT;
          end else if (cnt_q == TO_LAST) begin
            res_q   <= '0;
            cyc_q   <= TO_FULL;
            to_q    <= 1'b1;
            state_q <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            cnt_q   <= '0;
            state_q <= S_CPU_RST;
          end
        end
        default: state_q <= S_CPU_RST;
      endcase
    end
  end

`ifdef CPU_DISPATCH_SELFCHECK_EN
  logic [BIT_WIDTH-1:0] prod_d;
  logic [BIT_WIDTH-1:0] prod_q;
  logic                 mm_q;

  assign prod_d       = in_a * in_b;
  assign out_mismatch = mm_q;

  // Capture the reference product on accept and compare it on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      mm_q   <= 1'b0;
    end else begin
      if (accept) prod_q <= prod_d;
      if (wait_done) mm_q <= (cpu_result != prod_q);
      else if (wait_to) mm_q <= 1'b0;
    end
  end
`else
  assign out_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_job_dispatcher.sv
// Directed bench for cpu_job_dispatcher with a behavioural CPU model.
// Expected responses are queued at accept and checked at the output handshake.
module tb_cpu_job_dispatcher;

  localparam int W  = 16;
  localparam int TO = 500;
  localparam int RC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cpu_start;
  logic [W-1:0] cpu_operand_a;
  logic [W-1:0] cpu_operand_b;
  logic         cpu_rst_n;
  logic [W-1:0] cpu_result;
  logic         cpu_done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_timeout;
  logic [15:0]  out_cycles;
  logic         out_mismatch;
  logic         busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         to;
    logic [15:0]  cyc;
    logic         mm;
  } exp_t;

  exp_t sb[$];

  // CPU model: raises done when its wait counter hits model_delay (-1 = never).
  int           model_delay = -1;
  logic [W-1:0] model_res = '0;
  int           wcnt = 0;
  logic         active = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cpu_rst_n) begin
      active <= 1'b0;
      wcnt   <= 0;
    end else if (cpu_start) begin
      active <= 1'b1;
      wcnt   <= 0;
    end else if (active) begin
      wcnt <= wcnt + 1;
    end
  end

  assign cpu_done   = active && (wcnt == model_delay);
  assign cpu_result = model_res;

  cpu_job_dispatcher #(
    .BIT_WIDTH(W),
    .TIMEOUT_CYCLES(TO),
    .CPU_RST_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .cpu_start(cpu_start),
    .cpu_operand_a(cpu_operand_a),
    .cpu_operand_b(cpu_operand_b),
    .cpu_rst_n(cpu_rst_n),
    .cpu_result(cpu_result),
    .cpu_done(cpu_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_timeout(out_timeout),
    .out_cycles(out_cycles),
    .out_mismatch(out_mismatch),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_n"}, 32'(cpu_rst_n), 0);
    chk({tag, "_start"}, 32'(cpu_start), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_result"}, 32'(out_result), 0);
    chk({tag, "_timeout"}, 32'(out_timeout), 0);
    chk({tag, "_cycles"}, 32'(out_cycles), 0);
    chk({tag, "_mismatch"}, 32'(out_mismatch), 0);
    chk({tag, "_opa"}, 32'(cpu_operand_a), 0);
    chk({tag, "_opb"}, 32'(cpu_operand_b), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
    end
    chk({tag, "_ready_lat"}, 32'(n), RC + 1);
  endtask

  // Offer one job, check START timing, and push the expected response.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int delay, input logic [W-1:0] res);
    exp_t e;
    logic [W-1:0] p;
    p           = a * b;
    model_delay = delay;
    model_res   = res;
    e.res = (delay < 0) ? '0 : res;
    e.to  = (delay < 0);
    e.cyc = (delay < 0) ? 16'(TO) : 16'(delay);
`ifdef CPU_DISPATCH_SELFCHECK_EN
    e.mm = (delay >= 0) && (res != p);
`else
    e.mm = 1'b0;
`endif
    chk("accept_ready", 32'(in_ready), 1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("start_at_accept_plus1", 32'(cpu_start), 1);
    chk("opa", 32'(cpu_operand_a), 32'(a));
    chk("opb", 32'(cpu_operand_b), 32'(b));
  endtask

  task automatic finish_job(input int stall);
    exp_t e;
    int   w = 0;
    int   starts = 0;
    logic [W-1:0] r0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_valid) break;
      w++;
      if (cpu_start) starts++;
    end
    chk("wait_out_valid", 32'(out_valid), 1);
    chk("start_single", 32'(starts), 0);
    e = sb.pop_front();
    chk("wait_len", 32'(w), (e.to ? TO : 32'(e.cyc) + 1));
    r0 = out_result;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_result", 32'(out_result), 32'(r0));
    end
    chk("out_result", 32'(out_result), 32'(e.res));
    chk("out_timeout", 32'(out_timeout), 32'(e.to));
    chk("out_cycles", 32'(out_cycles), 32'(e.cyc));
    chk("out_mismatch", 32'(out_mismatch), 32'(e.mm));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_rst_n_1", 32'(cpu_rst_n), 0);
    @(negedge clk);
    chk("post_rst_n_2", 32'(cpu_rst_n), 0);
    @(negedge clk);
    chk("post_settle", 32'(cpu_rst_n), 1);
    chk("post_settle_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("post_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    wait_ready("por");

    launch(16'd3, 16'd5, 10, 16'd15);
    finish_job(0);

    launch(16'd255, 16'd255, 3, 16'd65025);
    finish_job(5);

    launch(16'd9, 16'd9, -1, 16'd81);
    finish_job(0);

    launch(16'd2, 16'd617, TO - 1, 16'd1234);
    finish_job(0);

    launch(16'd11, 16'd13, -1, 16'd143);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid");
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    wait_ready("mid");

    launch(16'd7, 16'd8, 4, 16'd56);
    finish_job(0);

    launch(16'd7, 16'd8, 2, 16'd57);
    finish_job(1);

    launch(16'd0, 16'd5, 0, 16'd0);
    finish_job(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_job_dispatcher.md
# cpu_job_dispatcher

Host-side initiator for `simple_cpu_top`: takes operand pairs over a valid/ready input stream and drives the CPU's `start`/`operand_a`/`operand_b` interface. It waits for `done` with a bounded timeout, returns `result` plus status over a valid/ready output stream, and resets the CPU between jobs. It is the synthesizable counterpart of the bench-side job loop, so multiply jobs can be streamed to the CPU in hardware.

## Interface

Parameters:
- `BIT_WIDTH`, 16: operand/result width; must match the CPU.
- `TIMEOUT_CYCLES`, 500: maximum WAIT cycles per job; range 1..65535.
- `CPU_RST_CYCLES`, 2: cycles `cpu_rst_n` is held low between jobs; range ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: job offered.
- `in_ready` output 1: dispatcher accepts a job.
- `in_a` input BIT_WIDTH: multiplicand.
- `in_b` input BIT_WIDTH: multiplier.
- `cpu_start` output 1: start pulse to the CPU.
- `cpu_operand_a` output BIT_WIDTH: operand A to the CPU.
- `cpu_operand_b` output BIT_WIDTH: operand B to the CPU.
- `cpu_rst_n` output 1: active-low CPU reset.
- `cpu_result` input BIT_WIDTH: CPU result.
- `cpu_done` input 1: CPU completion flag.
- `out_valid` output 1: response available.
- `out_ready` input 1: consumer accepts the response.
- `out_result` output BIT_WIDTH: captured result; 0 on timeout.
- `out_timeout` output 1: job hit the timeout.
- `out_cycles` output 16: WAIT cycle count.
- `out_mismatch` output 1: self-check failure (see Configuration).
- `busy` output 1: state ≠ IDLE.

## Operation

- FSM states: CPU_RST, SETTLE, IDLE, START, WAIT, OUT.
- **CPU_RST:** `cpu_rst_n`=0. A counter runs for `CPU_RST_CYCLES` cycles, then the FSM moves to SETTLE.
- **SETTLE:** `cpu_rst_n`=1 for exactly one cycle, then IDLE.
- **IDLE:** `in_ready`=1, which is the only state where it is 1. On `in_valid & in_ready`, `in_a`/`in_b` are registered onto `cpu_operand_a`/`cpu_operand_b` and the FSM moves to START. Operands stay stable until the next accept.
- **START:** `cpu_start`=1 for exactly this one cycle. Cycle counter is cleared to 0. Next state is WAIT.
- **WAIT:**
  - `cpu_done` sampled 1: `cpu_result` is latched into `out_result`, `out_cycles` takes the current counter value, `out_timeout`=0, and the FSM moves to OUT.
  - Otherwise, counter == `TIMEOUT_CYCLES`-1: `out_result`=0, `out_timeout`=1, `out_cycles`=`TIMEOUT_CYCLES`, and the FSM moves to OUT.
  - Otherwise the counter increments.
  - If done and timeout occur in the same cycle, done wins.
- **OUT:** `out_valid`=1. All `out_*` fields are held stable until `out_valid & out_ready`, then the FSM moves to CPU_RST.
- `cpu_done` is ignored outside WAIT. `cpu_result` is sampled only in WAIT.
- Result width is BIT_WIDTH. No extension or truncation is done by the dispatcher.
- **Reset (`rst`), including mid-job:**
  - The FSM goes to CPU_RST with its counter at 0 and the in-flight job is discarded.
  - `cpu_rst_n`=0, `cpu_start`=0, `in_ready`=0, `out_valid`=0, `busy`=1.
  - `out_result`, `out_timeout`, `out_cycles`, `out_mismatch`, `cpu_operand_a`, `cpu_operand_b` are all 0.

## Timing

- All outputs are registered or decoded directly from state. There is no combinational path from input to output.
- Accept edge N: `cpu_start` is high in cycle N+1, and WAIT begins at cycle N+2.
- `out_cycles` = the counter value in the cycle `cpu_done` is sampled. Done in the first WAIT cycle gives 0.
- WAIT lasts at most `TIMEOUT_CYCLES` cycles.
- `out_valid` rises one cycle after the cycle done is sampled, or one cycle after the timeout cycle.
- After the output handshake: `cpu_rst_n` is low for `CPU_RST_CYCLES` cycles, high for 1 SETTLE cycle, then `in_ready`=1.
- After `rst` deasserts: `in_ready` rises `CPU_RST_CYCLES`+1 cycles later.
- Throughput: one job per (3 + WAIT length + OUT stall + `CPU_RST_CYCLES` + 1) cycles.

## Configuration

- **`CPU_DISPATCH_SELFCHECK_EN` defined:**
  - On accept, the low BIT_WIDTH bits of `in_a*in_b` are registered.
  - On completion, `out_mismatch` = (`cpu_result` ≠ registered product).
  - On timeout, `out_mismatch`=0.
  - `out_mismatch` is held with the other `out_*` fields.
- **Not defined:** `out_mismatch` is tied to 0 and no multiplier is synthesized. The port stays present.

## Test plan

- 3,5 with a CPU model asserting done and result 15 after 10 WAIT cycles -> `out_result`=15, `out_cycles`=10, `out_timeout`=0, and `cpu_start` high exactly 1 cycle, at accept+1.
- 255,255 → 65025 with `out_ready` held low for 5 cycles -> `out_valid` stays 1 and fields stay stable. After the handshake, `cpu_rst_n` is low exactly 2 cycles and `in_ready` returns 3 cycles after the handshake.
- Model never asserts done, `TIMEOUT_CYCLES`=500 -> WAIT lasts 500 cycles, then `out_timeout`=1, `out_result`=0, `out_cycles`=500.
- Done asserted in the last timeout cycle (counter 499) -> completion, with `out_timeout`=0, `out_cycles`=499, and the result captured.
- `rst` pulsed mid-WAIT -> all outputs take reset values immediately and `in_ready` returns `CPU_RST_CYCLES`+1 cycles after release. A following job 7,8 → 56 completes normally.
- Model returns 57 for 7,8 -> `out_mismatch`=1 with `CPU_DISPATCH_SELFCHECK_EN` defined, 0 without. Correct 0,5 → 0 gives `out_mismatch`=0 in both builds.
